// File: rtl/sequenciador_porta.sv
// Door sequencer: drives the animation stage open/close command from cabin requests and door feedback.
// Optional watchdog with sticky FALHA state enabled by defining PORTA_WATCHDOG_EN.
module sequenciador_porta #(
  parameter int unsigned DWELL_CYCLES   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       parado,
  input  logic       pedido_abrir,
  input  logic       botao_abrir,
  input  logic       botao_fechar,
  input  logic       obstaculo,
  input  logic       port_a,
  input  logic       port_f,
  output logic       control_port,
  output logic       liberado,
  output logic       ocupado,
  output logic       falha,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    FECHADA  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTA   = 3'd2,
    FECHANDO = 3'd3
`ifdef PORTA_WATCHDOG_EN
    , FALHA  = 3'd4
`endif
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL_CYCLES - 1);

  // Counters must be able to reach both cycle limits without saturating early.
  if (CNT_W < $clog2(DWELL_CYCLES)) begin : g_dwell_width_check
    $error("CNT_W too small for DWELL_CYCLES");
  end
  if (CNT_W < $clog2(TIMEOUT_CYCLES)) begin : g_timeout_width_check
    $error("CNT_W too small for TIMEOUT_CYCLES");
  end

  estado_t          state_r;
  estado_t          next_state_s;
  logic [CNT_W-1:0] dwell_cnt_r;
  logic [CNT_W-1:0] next_dwell_s;
  logic             control_s;
  logic             liberado_s;
  logic             ocupado_s;

`ifdef PORTA_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_END = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt_r;
  logic [CNT_W-1:0] next_wd_s;
  logic             falha_s;
  logic             falha_r;
`endif

  // Next-state and dwell counter logic; open requests always win over close.
  always_comb begin
    next_state_s = state_r;
    next_dwell_s = dwell_cnt_r;
    case (state_r)
      FECHADA: begin
        if (parado && (pedido_abrir || botao_abrir)) begin
          next_state_s = ABRINDO;
        end else begin
          next_state_s = FECHADA;
        end
      end
      ABRINDO: begin
        if (port_a) begin
          next_state_s = ABERTA;
          next_dwell_s = {CNT_W{1'b0}};
        end else begin
          next_state_s = ABRINDO;
        end
      end
      ABERTA: begin
        if (dwell_cnt_r != CNT_MAX) begin
          next_dwell_s = dwell_cnt_r + 1'b1;
        end else begin
          next_dwell_s = dwell_cnt_r;
        end
        if (botao_abrir || obstaculo) begin
          next_dwell_s = {CNT_W{1'b0}};
        end else if (botao_fechar || (dwell_cnt_r == DWELL_END)) begin
          next_state_s = FECHANDO;
        end else begin
          next_state_s = ABERTA;
        end
      end
      FECHANDO: begin
        if (obstaculo || botao_abrir) begin
          next_state_s = ABRINDO;
        end else if (port_f) begin
          next_state_s = FECHADA;
        end else begin
          next_state_s = FECHANDO;
        end
      end
`ifdef PORTA_WATCHDOG_EN
      FALHA: begin
        next_state_s = FALHA;
      end
`endif
      default: begin
        next_state_s = FECHANDO;
      end
    endcase

`ifdef PORTA_WATCHDOG_EN
    // Watchdog restarts on every state change and trips after a full timeout in motion.
    next_wd_s = wd_cnt_r;
    if (next_state_s != state_r) begin
      next_wd_s = {CNT_W{1'b0}};
    end else if ((state_r == ABRINDO) || (state_r == FECHANDO)) begin
      if (wd_cnt_r >= WD_END) begin
        next_state_s = FALHA;
        next_wd_s    = {CNT_W{1'b0}};
      end else if (wd_cnt_r != CNT_MAX) begin
        next_wd_s = wd_cnt_r + 1'b1;
      end else begin
        next_wd_s = wd_cnt_r;
      end
    end else begin
      next_wd_s = wd_cnt_r;
    end
`endif
  end

  // Output decode from the upcoming state so registered outputs track the state register.
  always_comb begin
    control_s  = 1'b1;
    liberado_s = 1'b0;
    ocupado_s  = 1'b0;
`ifdef PORTA_WATCHDOG_EN
    falha_s    = 1'b0;
`endif
    case (next_state_s)
      FECHADA:  begin control_s = 1'b1; liberado_s = 1'b1; end
      ABRINDO:  begin control_s = 1'b0; ocupado_s  = 1'b1; end
      ABERTA:   begin control_s = 1'b0; end
      FECHANDO: begin control_s = 1'b1; ocupado_s  = 1'b1; end
`ifdef PORTA_WATCHDOG_EN
      FALHA:    begin control_s = 1'b0; falha_s    = 1'b1; end
`endif
      default:  begin control_s = 1'b1; ocupado_s  = 1'b1; end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= FECHANDO;
      dwell_cnt_r  <= {CNT_W{1'b0}};
      control_port <= 1'b1;
      liberado     <= 1'b0;
      ocupado      <= 1'b1;
      estado       <= 3'd3;
    end else begin
      state_r      <= next_state_s;
      dwell_cnt_r  <= next_dwell_s;
      control_port <= control_s;
      liberado     <= liberado_s;
      ocupado      <= ocupado_s;
      estado       <= next_state_s;
    end
  end

`ifdef PORTA_WATCHDOG_EN
  // Watchdog counter and sticky fault flag.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r <= {CNT_W{1'b0}};
      falha_r  <= 1'b0;
    end else begin
      wd_cnt_r <= next_wd_s;
      falha_r  <= falha_s;
    end
  end

  assign falha = falha_r;
`else
  assign falha = 1'b0;
`endif

endmodule
